// File: rtl/pal_macro_array.sv
// Run-time configurable PAL array: NI inputs, NO macrocells with q feedback, NP product terms each.
// Fuse map, REG and POL bits are loaded serially (index 0 first) before the array runs.
module pal_macro_array #(
  parameter int NI = 8,
  parameter int NO = 8,
  parameter int NP = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NI-1:0] i,
  output logic [NO-1:0] o,
  input  logic          cfg_start,
  input  logic          cfg_valid,
  input  logic          cfg_din,
  output logic          cfg_done,
  output logic          run
);

  localparam int NL    = NI + NO;
  localparam int FUSES = NO * NP * 2 * NL;
  localparam int NBITS = FUSES + 2 * NO;
  localparam int CW    = $clog2(NBITS + 1);

  localparam logic [CW-1:0]    LAST_BIT = CW'(NBITS - 1);
  // Unprogrammed part: every fuse intact, all cells registered, active high.
  localparam logic [NBITS-1:0] CFG_RST  = {{NO{1'b0}}, {NO{1'b1}}, {FUSES{1'b1}}};

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] cfg_q, cfg_d;
  logic [NO-1:0]    mq_q, mq_d;
  logic             done_q, done_d;

  logic [NL-1:0]    lits;
  logic [NO*NP-1:0] term;
  logic [NO-1:0]    f;
  logic [NO-1:0]    reg_cfg;
  logic [NO-1:0]    pol_cfg;

  // Feedback always comes from the registers, so the array has no combinational loop.
  assign lits    = {mq_q, i};
  assign reg_cfg = cfg_q[FUSES +: NO];
  assign pol_cfg = cfg_q[FUSES + NO +: NO];

  always_comb begin
    term = '1;
    for (int p = 0; p < NO * NP; p++) begin
      for (int l = 0; l < NL; l++) begin
        if (cfg_q[(p * NL + l) * 2] && !lits[l]) term[p] = 1'b0;
        if (cfg_q[(p * NL + l) * 2 + 1] && lits[l]) term[p] = 1'b0;
      end
    end
  end

  always_comb begin
    f = '0;
    for (int n = 0; n < NO; n++) begin
      for (int t = 0; t < NP; t++) begin
        f[n] = f[n] | term[n * NP + t];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    mq_d    = mq_q;
    done_d  = 1'b0;
    if (cfg_start) begin
      // Start wins over a coincident valid bit and always restarts from bit 0.
      state_d = LOAD;
      cnt_d   = '0;
      mq_d    = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (cfg_valid) begin
            cfg_d[cnt_q] = cfg_din;
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
              state_d = RUN;
              cnt_d   = '0;
              done_d  = 1'b1;
            end
          end
        end
        RUN:     mq_d = f;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNCFG;
      cnt_q   <= '0;
      cfg_q   <= CFG_RST;
      mq_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      mq_q    <= mq_d;
      done_q  <= done_d;
    end
  end

  assign run      = (state_q == RUN);
  assign cfg_done = done_q;
  assign o        = run ? (((reg_cfg & mq_q) | (~reg_cfg & f)) ^ pol_cfg) : '0;

endmodule

// File: tb/tb_pal_macro_array.sv
// Directed bench for pal_macro_array: builds fuse maps locally, loads them serially, checks outputs.
module tb_pal_macro_array;

  localparam int NI    = 8;
  localparam int NO    = 8;
  localparam int NP    = 8;
  localparam int NL    = NI + NO;
  localparam int FUSES = NO * NP * 2 * NL;
  localparam int NBITS = FUSES + 2 * NO;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] i;
  logic [NO-1:0] o;
  logic          cfg_start;
  logic          cfg_valid;
  logic          cfg_din;
  logic          cfg_done;
  logic          run;

  pal_macro_array #(.NI(NI), .NO(NO), .NP(NP)) dut (
    .clk(clk), .rst(rst), .i(i), .o(o),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_din(cfg_din),
    .cfg_done(cfg_done), .run(run)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [NBITS-1:0] map;

  typedef struct {
    logic [7:0] iv;
    logic [7:0] exp_comb;
    logic [7:0] exp_reg;
  } vec_t;
  vec_t vecs[8];

  always @(negedge clk) if (cfg_done === 1'b1) done_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int fi(input int n, input int t, input int l, input int c);
    return ((n * NP + t) * NL + l) * 2 + c;
  endfunction

  task automatic clear_term(input int n, input int t);
    for (int l = 0; l < NL; l++) begin
      map[fi(n, t, l, 0)] = 1'b0;
      map[fi(n, t, l, 1)] = 1'b0;
    end
  endtask

  // Every term gets i[0] & ~i[0], i.e. constant 0.
  task automatic kill_all();
    map = '0;
    for (int n = 0; n < NO; n++)
      for (int t = 0; t < NP; t++) begin
        map[fi(n, t, 0, 0)] = 1'b1;
        map[fi(n, t, 0, 1)] = 1'b1;
      end
  endtask

  task automatic map_allones(input logic [7:0] pol);
    map = '1;
    map[FUSES + NO +: NO] = pol;
  endtask

  task automatic map_follow(input logic reg0);
    kill_all();
    clear_term(0, 0);
    map[fi(0, 0, 0, 0)] = 1'b1;
    map[FUSES +: NO] = {7'h7F, reg0};
    map[FUSES + NO +: NO] = 8'h00;
  endtask

  // q[n] ^= &q[n-1:0] as sum of products: ~q[n]&A  |  q[n]&~q[k] for each k<n.
  task automatic map_counter();
    kill_all();
    for (int n = 0; n < NO; n++) begin
      for (int t = 0; t <= n; t++) clear_term(n, t);
      map[fi(n, 0, NI + n, 1)] = 1'b1;
      for (int k = 0; k < n; k++) begin
        map[fi(n, 0, NI + k, 0)]     = 1'b1;
        map[fi(n, k + 1, NI + n, 0)] = 1'b1;
        map[fi(n, k + 1, NI + k, 1)] = 1'b1;
      end
    end
    map[FUSES +: NO] = 8'hFF;
    map[FUSES + NO +: NO] = 8'h00;
  endtask

  task automatic do_start();
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_din   = ~map[0];
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic send_bits(input string nm, input int nb);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < nb; k++) begin
      cfg_valid = 1'b1;
      cfg_din   = map[k];
      tick();
      if (k < nb - 1 && (run !== 1'b0 || o !== 8'h00)) seen = 1'b1;
    end
    cfg_valid = 1'b0;
    chk({nm, "_idle_during_load"}, 32'(seen), 0);
  endtask

  task automatic load_full(input string nm);
    do_start();
    send_bits(nm, NBITS);
    chk({nm, "_cfg_done"}, 32'(cfg_done), 1);
    chk({nm, "_run"}, 32'(run), 1);
  endtask

  initial begin
    int d5;
    int d6;
    logic flag;

    vecs[0] = '{8'h00, 8'h00, 8'h00};
    vecs[1] = '{8'h01, 8'h01, 8'h00};
    vecs[2] = '{8'hFE, 8'h00, 8'h01};
    vecs[3] = '{8'hFF, 8'h01, 8'h00};
    vecs[4] = '{8'h03, 8'h01, 8'h01};
    vecs[5] = '{8'h02, 8'h00, 8'h01};
    vecs[6] = '{8'h55, 8'h01, 8'h00};
    vecs[7] = '{8'hAA, 8'h00, 8'h01};

    rst = 1'b1; i = '0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_din = 1'b0;
    tick();
    tick();
    chk("rst_o", 32'(o), 0);
    chk("rst_run", 32'(run), 0);
    chk("rst_cfg_done", 32'(cfg_done), 0);
    rst = 1'b0;

    // Unconfigured part stays dark.
    flag = 1'b0;
    for (int k = 0; k < 50; k++) begin
      i = 8'(k * 37);
      tick();
      if (o !== 8'h00 || run !== 1'b0) flag = 1'b1;
    end
    chk("uncfg_idle", 32'(flag), 0);
    chk("uncfg_no_done", 32'(done_cnt), 0);

    map_allones(8'h00);
    load_full("ones_pol0");
    chk("ones_pol0_o", 32'(o), 0);
    i = 8'hA5;
    tick();
    chk("ones_pol0_o2", 32'(o), 0);
    chk("ones_pol0_done_low", 32'(cfg_done), 0);
    map_allones(8'hFF);
    load_full("ones_polff");
    chk("ones_polff_o", 32'(o), 32'hFF);
    i = 8'h5A;
    tick();
    chk("ones_polff_o2", 32'(o), 32'hFF);

    map_follow(1'b0);
    load_full("comb");
    for (int k = 0; k < 8; k++) begin
      i = vecs[k].iv;
      #1;
      chk($sformatf("comb_v%0d", k), 32'(o), 32'(vecs[k].exp_comb));
      tick();
    end

    map_follow(1'b1);
    load_full("reg");
    for (int k = 0; k < 8; k++) begin
      i = vecs[k].iv;
      #1;
      chk($sformatf("reg_v%0d", k), 32'(o), 32'(vecs[k].exp_reg));
      tick();
    end

    map_counter();
    load_full("cnt");
    for (int k = 0; k <= 256; k++) begin
      chk($sformatf("cnt_%0d", k), 32'(o), 32'(k & 255));
      if (k == 1) chk("cnt_done_low", 32'(cfg_done), 0);
      tick();
    end

    // Abort a load after 1000 bits of another map, then load the counter again.
    d5 = done_cnt;
    map_allones(8'hFF);
    do_start();
    send_bits("abort", 1000);
    chk("abort_run", 32'(run), 0);
    map_counter();
    load_full("reload");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reload_cnt_%0d", k), 32'(o), 32'(k));
      tick();
    end
    chk("reload_one_done", 32'(done_cnt - d5), 1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_run_o", 32'(o), 0);
    chk("rst_run_run", 32'(run), 0);
    d6 = done_cnt;
    flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cfg_valid = 1'b1;
      cfg_din   = k[0];
      tick();
      if (o !== 8'h00 || run !== 1'b0) flag = 1'b1;
    end
    cfg_valid = 1'b0;
    chk("post_rst_valid_ignored", 32'(flag), 0);

    map_allones(8'hFF);
    do_start();
    send_bits("midload", 500);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_load_o", 32'(o), 0);
    chk("rst_load_run", 32'(run), 0);
    send_bits("orphan", NBITS);
    chk("orphan_run", 32'(run), 0);
    chk("orphan_o", 32'(o), 0);
    tick();
    chk("orphan_no_done", 32'(done_cnt - d6), 0);
    load_full("recover");
    chk("recover_o", 32'(o), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
